// File: rtl/bram_frame_streamer.sv
// bram_frame_streamer: reads a rectangular window of a frame BRAM in raster
// order and pushes each pixel into a downstream FIFO (out_wr_en / out_full).
// The BRAM has a 1-cycle read latency. Returned pixels land in a 2-entry skid
// buffer. A new read is issued only when that buffer is guaranteed to have
// room for the data, so backpressure never drops or duplicates a pixel.
// Optional feature macro: STREAM_SOF_EN adds out_sof, a start-of-frame flag.
// The flag travels through the skid buffer alongside the pixel data.
module bram_frame_streamer #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int IMAGE_SIZE = WIDTH * HEIGHT,
  parameter int STARTING_X = 0,
  parameter int STARTING_Y = 0,
  parameter int OUT_WIDTH  = WIDTH,
  parameter int OUT_HEIGHT = HEIGHT,
  parameter int DATA_WIDTH = 24,
  localparam int ADDR_W    = $clog2(IMAGE_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full
`ifdef STREAM_SOF_EN
  ,
  output logic                  out_sof
`endif
);

  localparam int COL_W = $clog2(OUT_WIDTH + 1);
  localparam int ROW_W = $clog2(OUT_HEIGHT + 1);
`ifdef STREAM_SOF_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            state, state_next;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [1:0]        entries;
  logic              inflight;
  logic [EW-1:0]     slot0, slot1;
  logic [EW-1:0]     push_word;
  logic [2:0]        occ;
  logic              issue, pop, last_read;
  logic [ADDR_W-1:0] addr_calc;

  // The head entry drives the FIFO. A pop is simply an accepted write.
  assign out_wr_en = (entries != 2'd0) && !out_full;
  assign out_din   = slot0[DATA_WIDTH-1:0];
  assign pop       = out_wr_en;

  // Issue a read only if the buffer will still have room when its data returns.
  assign occ       = {1'b0, entries} + {2'b00, inflight};
  assign issue     = (state == S_STREAM) && (occ < (3'd2 + {2'b00, pop}));
  assign last_read = (col == COL_W'(OUT_WIDTH - 1)) && (row == ROW_W'(OUT_HEIGHT - 1));

`ifdef STREAM_SOF_EN
  logic inflight_sof;
  assign push_word = {inflight_sof, bram_rd_data};
  assign out_sof   = out_wr_en & slot0[DATA_WIDTH];

  // Tag the read of the window's first pixel so the flag rides with its data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) inflight_sof <= 1'b0;
    else        inflight_sof <= issue && (col == '0) && (row == '0);
  end
`else
  assign push_word = bram_rd_data;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Leave DRAIN once the final buffered pixel pops this cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_STREAM;
      S_STREAM: if (issue && last_read) state_next = S_DRAIN;
      S_DRAIN:  if (!inflight && ((entries == 2'd0) || ((entries == 2'd1) && pop)))
                  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state == S_STREAM) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // Raster address of the current window pixel. The address is held at 0 outside STREAM.
  always_comb begin
    addr_calc = (ADDR_W'(STARTING_Y) + ADDR_W'(row)) * ADDR_W'(WIDTH)
              + ADDR_W'(STARTING_X) + ADDR_W'(col);
    bram_rd_addr = (state == S_STREAM) ? addr_calc : '0;
  end

  // Window position counters: cleared while idle, advanced on every issued read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (state == S_IDLE) begin
      col <= '0;
      row <= '0;
    end else if (issue) begin
      if (col == COL_W'(OUT_WIDTH - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Skid buffer: slot0 is the head. slot0 keeps its value when the buffer empties.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      entries  <= 2'd0;
      slot0    <= '0;
      slot1    <= '0;
    end else begin
      inflight <= issue;
      entries  <= entries + {1'b0, inflight} - {1'b0, pop};
      case (entries)
        2'd0: if (inflight) slot0 <= push_word;
        2'd1: begin
          if (pop) begin
            if (inflight) slot0 <= push_word;
          end else if (inflight) begin
            slot1 <= push_word;
          end
        end
        default: begin
          if (pop) begin
            slot0 <= slot1;
            if (inflight) slot1 <= push_word;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_frame_streamer.sv
// Testbench for bram_frame_streamer: 8x4 frame, 4x2 window at (2,1), BRAM data = address.
// A second instance streams a 1x1 window. Define STREAM_SOF_EN to also check out_sof.
module tb_bram_frame_streamer;
  localparam int W = 8, H = 4, SX = 2, SY = 1, OW = 4, OH = 2, DW = 24;
  localparam int AW = $clog2(W * H);
  localparam int NPIX = OW * OH;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          out_full = 1'b0;
  logic          busy, done, out_wr_en;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data, out_din;

  logic          u1_start = 1'b0;
  logic          u1_full = 1'b0;
  logic          u1_busy, u1_done, u1_wr_en;
  logic [AW-1:0] u1_addr;
  logic [DW-1:0] u1_rd_data, u1_din;
`ifdef STREAM_SOF_EN
  logic          out_sof, u1_sof;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model and run bookkeeping. The compare process writes these; the main process reads them.
  int mode = 0;
  int wr_idx = 0;
  int done_cnt = 0;
  int cyc_n = 0;
  int start_n = 0;
  int last_wr_n = -100;
  int done_n = 0;
  logic [DW-1:0] got [NPIX];

  always #5 clock = ~clock;

  bram_frame_streamer #(
    .WIDTH(W), .HEIGHT(H), .STARTING_X(SX), .STARTING_Y(SY),
    .OUT_WIDTH(OW), .OUT_HEIGHT(OH), .DATA_WIDTH(DW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .out_wr_en(out_wr_en), .out_din(out_din), .out_full(out_full)
`ifdef STREAM_SOF_EN
    , .out_sof(out_sof)
`endif
  );

  bram_frame_streamer #(
    .WIDTH(W), .HEIGHT(H), .STARTING_X(SX), .STARTING_Y(SY),
    .OUT_WIDTH(1), .OUT_HEIGHT(1), .DATA_WIDTH(DW)
  ) dut1 (
    .clock(clock), .reset(reset), .start(u1_start), .busy(u1_busy), .done(u1_done),
    .bram_rd_addr(u1_addr), .bram_rd_data(u1_rd_data),
    .out_wr_en(u1_wr_en), .out_din(u1_din), .out_full(u1_full)
`ifdef STREAM_SOF_EN
    , .out_sof(u1_sof)
`endif
  );

  // BRAM models with a 1-cycle read latency and contents equal to the address.
  always @(posedge clock) begin
    bram_rd_data <= DW'(bram_rd_addr);
    u1_rd_data   <= DW'(u1_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Window pixel i in raster order, computed from the window geometry.
  function automatic logic [31:0] exp_pix(input int i);
    return 32'((SY + i / OW) * W + SX + i % OW);
  endfunction

  // Compare process: checks the DUT against the model on every cycle out of reset.
  always @(negedge clock) begin
    if (reset) begin
      cyc_n++;
`ifdef STREAM_SOF_EN
      if (out_wr_en || out_sof)
        chk("sof_first_pixel_only", out_sof, 32'(out_wr_en && (wr_idx == 0)));
`endif
      if (out_wr_en) begin
        chk("no_write_while_full", out_full, 0);
        chk("busy_while_writing", busy, 1);
        if (wr_idx >= NPIX) begin
          chk("extra_write", wr_idx + 1, NPIX);
        end else begin
          chk("pixel_order", out_din, exp_pix(wr_idx));
          got[wr_idx] = out_din;
          if (wr_idx == 0 && mode != 2) chk("first_write_latency", cyc_n - start_n, 3);
        end
        last_wr_n = cyc_n;
        wr_idx++;
      end
      if (done) begin
        done_cnt++;
        done_n = cyc_n;
        chk("done_after_last_write", cyc_n - last_wr_n, 1);
        chk("done_total_writes", wr_idx, NPIX);
      end
    end
  end

  // Run one window. m: 0 = free flowing, 1 = fixed 5-cycle stall, 2 = random full, 3 = start re-pulsed.
  task automatic run_frame(input int m);
    mode = m;
    wr_idx = 0;
    done_cnt = 0;
    last_wr_n = -100;
    out_full = 1'b0;
    start = 1'b1;
    @(posedge clock);
    start_n = cyc_n;
    #1 start = 1'b0;
    for (int k = 2; k < 400 && done_cnt == 0; k++) begin
      @(posedge clock);
      #1;
      case (m)
        1: out_full = (k >= 4 && k <= 8);
        2: out_full = 1'($urandom_range(0, 1));
        3: start = (k == 4);
        default: out_full = 1'b0;
      endcase
    end
    if (done_cnt == 0) chk("run_timeout", 0, 1);
    out_full = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("writes_per_run", wr_idx, NPIX);
    chk("done_pulses_per_run", done_cnt, 1);
    chk("busy_after_done", busy, 0);
    $display("[TB] run mode %0d: %0d writes, %0d done pulses", m, wr_idx, done_cnt);
  endtask

  initial begin
    int n1, d1;
    logic [DW-1:0] lit [NPIX];
    lit = '{24'd10, 24'd11, 24'd12, 24'd13, 24'd18, 24'd19, 24'd20, 24'd21};

    // Reset values while reset is held.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", out_wr_en, 0);
    chk("rst_din", out_din, 0);
    chk("rst_addr", bram_rd_addr, 0);
    chk("rst_u1_wr_en", u1_wr_en, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Free-flowing run: hand-computed sequence and completion cycle.
    run_frame(0);
    for (int i = 0; i < NPIX; i++) chk("literal_sequence", got[i], lit[i]);
    chk("nobp_done_cycle", done_n - start_n, 11);

    // Fixed stall covering the 2nd write: writes resume at cycle 9, and done arrives at cycle 16.
    run_frame(1);
    for (int i = 0; i < NPIX; i++) chk("bp_literal_sequence", got[i], lit[i]);
    chk("bp_done_cycle", done_n - start_n, 16);

    // start re-pulsed while busy is ignored.
    run_frame(3);
    chk("repulse_done_cycle", done_n - start_n, 11);

    // Random backpressure.
    for (int r = 0; r < 20; r++) run_frame(2);

    // Asynchronous reset after the 3rd write, while the 4th write is on the bus.
    mode = 0;
    wr_idx = 0;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clock);
    start_n = cyc_n;
    #1 start = 1'b0;
    for (int k = 0; k < 50 && wr_idx < 3; k++) @(posedge clock);
    if (wr_idx < 3) chk("midreset_reach_3_writes", wr_idx, 3);
    #2;
    chk("pre_reset_wr_en", out_wr_en, 1);
    reset = 1'b0;
    #1;
    chk("async_rst_wr_en", out_wr_en, 0);
    chk("async_rst_din", out_din, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_addr", bram_rd_addr, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    run_frame(0);
    chk("after_reset_first_pixel", got[0], 10);

    // 1x1 window on the second instance.
    n1 = 0;
    d1 = 0;
    u1_start = 1'b1;
    @(posedge clock);
    #1 u1_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
`ifdef STREAM_SOF_EN
      chk("u1_sof", u1_sof, u1_wr_en);
`endif
      if (u1_wr_en) begin
        n1++;
        chk("u1_pixel", u1_din, 10);
      end
      if (u1_done) d1++;
    end
    chk("u1_writes", n1, 1);
    chk("u1_done_pulses", d1, 1);
    $display("[TB] 1x1 run: %0d writes, %0d done pulses", n1, d1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_frame_streamer.md
Name: bram_frame_streamer

Overview:
- Reader/transmitter counterpart to the pixel FIFO write path: on a start pulse, reads a rectangular window of a frame BRAM in raster order and pushes each pixel into a downstream FIFO via wr_en/full.
- Feeds the mask, grayscale and output FIFOs from stored frames, so benches and top levels stop hand-coding readout loops.
- Sustains one pixel per cycle when the FIFO is not full.
- Never drops or duplicates a pixel under backpressure.

Parameters:
- WIDTH, 1280: full frame width in pixels (BRAM row pitch).
- HEIGHT, 720: full frame height.
- IMAGE_SIZE, WIDTH*HEIGHT: BRAM depth; address width is $clog2(IMAGE_SIZE).
- STARTING_X, 0: window left column.
- STARTING_Y, 0: window top row.
- OUT_WIDTH, WIDTH: window width in pixels.
- OUT_HEIGHT, HEIGHT: window height in pixels.
- DATA_WIDTH, 24: pixel width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin streaming one window; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final pixel is accepted by the FIFO.
- bram_rd_addr  out  $clog2(IMAGE_SIZE)  BRAM read address; BRAM read latency is 1 cycle.
- bram_rd_data  in  DATA_WIDTH  BRAM read data.
- out_wr_en  out  1  FIFO write strobe.
- out_din  out  DATA_WIDTH  FIFO write data.
- out_full  in  1  FIFO full.

Behaviour:
- Reset (async assert, sync release): state=IDLE, col=row=0, skid buffer empty, no read in flight. Outputs busy=0, done=0, out_wr_en=0, out_din=0, bram_rd_addr=0.
- States:
  - IDLE: start=1 at an edge -> STREAM. col and row are cleared.
  - STREAM: issues reads. After the last read is issued -> DRAIN.
  - DRAIN: waits until the skid buffer is empty and no read is in flight -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Address: bram_rd_addr = (STARTING_Y+row)*WIDTH + STARTING_X + col, computed at full width.
  - col wraps OUT_WIDTH-1 -> 0 and row increments.
  - The last read is col=OUT_WIDTH-1, row=OUT_HEIGHT-1.
- Skid buffer: 2 entries holding BRAM return data.
  - out_wr_en = (entries>0) && !out_full.
  - out_din = head entry; when entries=0, out_din holds its last value.
  - A pop occurs when out_wr_en=1.
- Read issue rule (STREAM only): issue in a cycle iff entries + inflight - pop < 2.
  - Issued-read data enters the skid buffer at the following edge.
  - With out_full held low this issues every cycle: full throughput.
- Latency: start accepted at edge E0 -> first read issued after E0 -> data captured at E2 -> out_wr_en=1 in the cycle after E2.
- Backpressure: while out_full=1 there are no writes. At most 2 pixels are buffered, then reads stall. On release, order is preserved exactly.
- start while busy is ignored.
- start and the DONE cycle coinciding: start is ignored; start must be re-asserted in IDLE.
- Reset mid-stream: immediate abort to reset values. No partial-frame resume; the FIFO owner handles flushing.
- Total writes per run = OUT_WIDTH*OUT_HEIGHT exactly.
- A window of 1x1 must work: one read, one write, then done.

Optional Feature:
- Macro STREAM_SOF_EN.
- When defined: adds output port out_sof (1 bit), which is high together with out_wr_en only for the window's first pixel (row 0, col 0). out_sof resets to 0. It is carried through the skid buffer as an extra bit so it stays aligned under backpressure.
- When undefined: the port and the extra storage bit are absent; all other behaviour is identical.

Test Plan:
- Common setup for all scenarios: WIDTH=8, HEIGHT=4, STARTING_X=2, STARTING_Y=1, OUT_WIDTH=4, OUT_HEIGHT=2. BRAM preloaded with data=address.
- No backpressure: start pulse with out_full=0 -> 8 consecutive writes 10,11,12,13,18,19,20,21. First out_wr_en 3 cycles after the start edge. done pulses once, 1 cycle after the last write. busy=0 afterwards.
- Backpressure: out_full=1 for 5 cycles starting at the 2nd write, then 0 -> same 8-value sequence with no gaps in value order. No write while full. Buffered depth never exceeds 2.
- Random backpressure: 50% random out_full over 20 runs -> each run yields exactly 8 writes in order and exactly one done pulse.
- Mid-stream reset: reset asserted asynchronously after the 3rd write -> outputs zero immediately without waiting for a clock edge. A new start then streams the full 8 pixels from 10.
- Corner cases:
  - start re-pulsed while busy -> ignored; exactly 8 writes.
  - OUT_WIDTH=OUT_HEIGHT=1 -> single write of 10.
  - With STREAM_SOF_EN defined, out_sof=1 only on the write of 10.
